// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: address width, reset PC, instruction word and fetch entry.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        instr_t            instr;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular entry store for the fetch queue: push at tail, pop at head, flush empties it.
// The head entry is read combinationally so a pushed entry is visible the next cycle.
module ifq_fifo #(
    parameter int  DEPTH = 4,
    parameter type entry_t = cpu_pkg::fetch_entry_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head_data,
    output logic [CNT_W-1:0] occupancy
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH naturally.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && !flush && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tracks outstanding/stale beats across
// redirects, buffers returned words for decode. Optional same-cycle bypass: IFQ_BYPASS_EN.
module ifetch_queue
    import cpu_pkg::instr_t;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    localparam int             CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [31:0]      dec_instr,
    output logic [XLEN-1:0]  dec_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] occupancy
);

    // Stale beats can pile up over several redirects, so this counter has headroom beyond DEPTH.
    localparam int STALE_W = CNT_W + 4;

    typedef struct packed {
        instr_t          instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [STALE_W-1:0] stale_q, stale_d;

    logic [CNT_W-1:0] fifo_occ;
    logic [CNT_W:0]   inflight;
    logic             req_fire, rsp_stale, rsp_live, rsp_counted;
    logic             bypass, push, pop;
    entry_t           push_entry, head_entry;
    logic [XLEN-1:0]  redirect_aligned;

    assign inflight         = {1'b0, fifo_occ} + {1'b0, outstanding_q};
    assign imem_req_valid   = (inflight < (CNT_W + 1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr    = fetch_pc_q;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Beats owed to an abandoned stream are always older than live ones, so they drain first.
    assign rsp_stale   = imem_rsp_valid && (stale_q != '0);
    assign rsp_live    = imem_rsp_valid && (stale_q == '0) && (outstanding_q != '0);
    assign rsp_counted = rsp_stale || rsp_live;

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_live && (fifo_occ == '0) && dec_ready && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = rsp_live && !redirect_valid && !bypass;
    assign pop  = (fifo_occ != '0) && dec_ready && !redirect_valid;

    always_comb begin
        push_entry       = '0;
        push_entry.instr = imem_rsp_data;
        push_entry.pc    = rsp_pc_q;
    end

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (CLK),
        .srst      (Reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .occupancy (fifo_occ)
    );

    assign occupancy = fifo_occ;
    assign dec_valid = !redirect_valid && ((fifo_occ != '0) || bypass);

    always_comb begin
        dec_instr = '0;
        dec_pc    = '0;
        if (fifo_occ != '0) begin
            dec_instr = head_entry.instr;
            dec_pc    = head_entry.pc;
        end else if (bypass) begin
            dec_instr = imem_rsp_data;
            dec_pc    = rsp_pc_q;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a beat landing now is already accounted for.
            fetch_pc_d    = redirect_aligned;
            rsp_pc_d      = redirect_aligned;
            outstanding_d = '0;
            stale_d       = stale_q + STALE_W'(outstanding_q) - STALE_W'(rsp_counted);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
            if (rsp_stale) stale_d = stale_q - STALE_W'(1);
            if (rsp_live)  rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

endmodule
